// File: rtl/alu_mdu.sv
// alu_mdu -- execute-stage arithmetic unit for the pipelined MIPS core.
//
// Purpose:
//   Single-cycle combinational ALU (add/sub, logic, compares, shifts, LUI)
//   alongside a multi-cycle multiply/divide unit. The MD unit owns the
//   architectural HI/LO registers. It raises busy while an operation is in
//   flight so the hazard unit can stall MD-dependent instructions.
//
// Parameters:
//   WIDTH    datapath width; an even power of two, at least 8
//   MUL_LAT  busy cycles for MULT/MULTU (at least 1)
//   DIV_LAT  busy cycles for DIV/DIVU (at least 1)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   A, B      in   operands; shift amount is A[log2(WIDTH)-1:0]
//   ALUCtrl   in   ALU op select (0 ADD .. 11 LUI, 12-15 give 0)
//   result    out  combinational ALU result
//   zero      out  A == B
//   md_start  in   one-cycle MD request
//   md_op     in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
//   busy      out  MD operation in flight
//   hi, lo    out  architectural HI/LO registers
//
// Configuration macro:
//   ALU_MDU_DIV_EN  when defined, DIV/DIVU are built. When undefined, the
//                   divider is absent and ops 2/3 are ignored like ops 6/7.

module alu_mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUCtrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int MAXL  = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW    = $clog2(MAXL + 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic             done;

  logic [SHW-1:0]   shamt;
  logic             slt, sltu;

  // Combinational ALU. This path deliberately has no dependence on MD state.
  assign shamt = A[SHW-1:0];
  assign slt   = $signed(A) < $signed(B);
  assign sltu  = A < B;
  assign zero  = (A == B);

  always_comb begin
    result = '0;
    case (ALUCtrl)
      4'd0:    result = A + B;
      4'd1:    result = A - B;
      4'd2:    result = A | B;
      4'd3:    result = A & B;
      4'd4:    result = A ^ B;
      4'd5:    result = ~(A | B);
      4'd6:    result = {{(WIDTH-1){1'b0}}, slt};
      4'd7:    result = {{(WIDTH-1){1'b0}}, sltu};
      4'd8:    result = B << shamt;
      4'd9:    result = B >> shamt;
      4'd10:   result = WIDTH'($signed(B) >>> shamt);
      4'd11:   result = B << (WIDTH / 2);
      default: result = '0;
    endcase
  end

  // Request decode. Ops 0/2 are the signed flavours, so bit 0 low = signed.
  logic is_mul, is_div, is_mt, signed_op, op_ok, launch, write_mt;

  assign is_mul    = (md_op[2:1] == 2'b00);
  assign is_div    = (md_op[2:1] == 2'b01);
  assign is_mt     = (md_op[2:1] == 2'b10);
  assign signed_op = ~md_op[0];

`ifdef ALU_MDU_DIV_EN
  assign op_ok = is_mul | is_div;
`else
  assign op_ok = is_mul;
`endif

  assign launch   = md_start && (state == IDLE) && op_ok;
  assign write_mt = md_start && (state == IDLE) && is_mt;

  // Multiplier: sign- or zero-extend both operands to 2*WIDTH so a single
  // unsigned multiply yields the correct low 2*WIDTH bits in both modes.
  logic [2*WIDTH-1:0] a_ext, b_ext, product;

  assign a_ext   = signed_op ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
  assign b_ext   = signed_op ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
  assign product = a_ext * b_ext;

`ifdef ALU_MDU_DIV_EN
  // Divider works on magnitudes and restores signs afterwards. MIN / -1
  // needs no special case: |MIN| negated wraps back to MIN, remainder 0.
  logic             a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] abs_a, abs_b, divisor, q_mag, r_mag, quot, rem;

  assign a_neg    = signed_op & A[WIDTH-1];
  assign b_neg    = signed_op & B[WIDTH-1];
  assign abs_a    = a_neg ? -A : A;
  assign abs_b    = b_neg ? -B : B;
  assign div_zero = (B == '0);
  assign divisor  = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
  assign q_mag    = abs_a / divisor;
  assign r_mag    = abs_a % divisor;
  assign quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem      = a_neg ? -r_mag : r_mag;
`endif

  always_comb begin
    md_hi = product[2*WIDTH-1:WIDTH];
    md_lo = product[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
    if (is_div) begin
      md_hi = div_zero ? A  : rem;
      md_lo = div_zero ? '1 : quot;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = RUN;
      RUN:     if (count == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; busy comes straight from the state flop.
  always_comb begin
    busy = (state == RUN);
    done = (state == RUN) && (count == '0);
  end

  // Counter, pending result and HI/LO. The result is computed once at launch
  // so later operand changes cannot affect it; HI/LO only move on completion
  // or on an accepted MTHI/MTLO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (launch) begin
        count   <= is_div ? DIV_CNT : MUL_CNT;
        pend_hi <= md_hi;
        pend_lo <= md_lo;
      end else if ((state == RUN) && (count != '0)) begin
        count <= count - CW'(1);
      end

      if (done) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end else if (write_mt) begin
        if (md_op[0]) lo <= A;
        else          hi <= A;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu -- self-checking bench for alu_mdu (WIDTH=32, MUL_LAT=5,
// DIV_LAT=10). MD results are predicted by a reference model at launch,
// pushed to a scoreboard queue and popped when busy drops. The divide tests
// build only when ALU_MDU_DIV_EN is defined; otherwise ops 2/3 are checked
// to be ignored.

module tb_alu_mdu;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic          clk;
  logic          reset;
  logic [W-1:0]  A, B;
  logic [3:0]    ALUCtrl;
  logic [W-1:0]  result;
  logic          zero;
  logic          md_start;
  logic [2:0]    md_op;
  logic          busy;
  logic [W-1:0]  hi, lo;

  int            checks = 0;
  int            errors = 0;
  logic [63:0]   sb[$];

  alu_mdu #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .ALUCtrl(ALUCtrl),
    .result(result), .zero(zero), .md_start(md_start), .md_op(md_op),
    .busy(busy), .hi(hi), .lo(lo)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for MULT/MULTU, returning {hi, lo}.
  function automatic logic [63:0] model_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    if (op == 3'd0) p = longint'($signed(a)) * longint'($signed(b));
    else            p = longint'({32'b0, a}) * longint'({32'b0, b});
    return p;
  endfunction

  // Reference model for DIV/DIVU, returning {hi, lo}.
  function automatic logic [63:0] model_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sbv;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == 3'd2) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = a; sbv = b;
      return {32'(sa % sbv), 32'(sa / sbv)};
    end
    return {a % b, a / b};
  endfunction

  task automatic test_reset();
    reset = 1'b0; md_start = 1'b0; md_op = 3'd0; A = '0; B = '0; ALUCtrl = '0;
    #2;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0", busy, hi, lo);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    logic [3:0]  ctl[15] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                            4'd8, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
    logic [31:0] av[15]  = '{32'hFFFFFFFF, 32'h0, 32'hF0F0, 32'hFF00FF00, 32'hFFFF0000,
                             32'h0F0F0F0F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h4, 32'h24,
                             32'h4, 32'h4, 32'h0, 32'h1, 32'hFFFFFFFF};
    logic [31:0] bv[15]  = '{32'h2, 32'h1, 32'h0F0F, 32'h0FF00FF0, 32'hFF00FF00,
                             32'hF0F0F0F0, 32'h1, 32'h1, 32'h1, 32'h3,
                             32'h80000000, 32'h80000000, 32'h0000ABCD, 32'h1, 32'hFFFFFFFF};
    logic [31:0] ev[15]  = '{32'h1, 32'hFFFFFFFF, 32'hFFFF, 32'h0F000F00, 32'h00FFFF00,
                             32'h0, 32'h1, 32'h0, 32'h10, 32'h30,
                             32'h08000000, 32'hF8000000, 32'hABCD0000, 32'h0, 32'h0};
    for (int i = 0; i < 15; i++) begin
      ALUCtrl = ctl[i]; A = av[i]; B = bv[i];
      #1;
      checks++;
      if (result !== ev[i]) begin
        errors++;
        $display("[TB] FAIL alu_op%0d_case%0d: got %h expected %h", ctl[i], i, result, ev[i]);
      end
      checks++;
      if (zero !== (av[i] == bv[i])) begin
        errors++;
        $display("[TB] FAIL zero_case%0d: got %b expected %b", i, zero, av[i] == bv[i]);
      end
      @(negedge clk);
    end
  endtask

  // Launches a MULT/DIV from the current falling edge, scrambles the operands
  // right after launch, and checks busy length, HI/LO hold and final result.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int lat, input string name);
    logic [31:0] old_hi, old_lo;
    logic [63:0] exp;
    int          cycles;
    logic        stale;
    sb.push_back(op[1] ? model_div(op, a, b) : model_mul(op, a, b));
    old_hi = hi; old_lo = lo;
    md_start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    md_start = 1'b0; A = ~a; B = ~b;
    cycles = 0; stale = 1'b0;
    while (busy && cycles < 200) begin
      cycles++;
      if (hi !== old_hi || lo !== old_lo) stale = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (cycles != lat) begin
      errors++;
      $display("[TB] FAIL %s_busy_cycles: got %0d expected %0d", name, cycles, lat);
    end
    checks++;
    if (stale) begin
      errors++;
      $display("[TB] FAIL %s_hold_during_run: got HI/LO change expected old %h/%h", name, old_hi, old_lo);
    end
    exp = sb.pop_front();
    checks++;
    if ({hi, lo} !== exp) begin
      errors++;
      $display("[TB] FAIL %s_result: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_mt(input logic [2:0] op, input logic [31:0] a);
    logic [63:0] exp;
    sb.push_back({(op == 3'd4) ? a : hi, (op == 3'd5) ? a : lo});
    md_start = 1'b1; md_op = op; A = a;
    @(negedge clk);
    md_start = 1'b0;
    exp = sb.pop_front();
    checks++;
    if ({hi, lo} !== exp || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mt_op%0d: got hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0", op, hi, lo, busy, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_mult();
    run_md(3'd0, 32'd5, 32'hFFFFFFFD, ML, "mult");
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      errors++;
      $display("[TB] FAIL mult_const: got %h_%h expected ffffffff_fffffff1", hi, lo);
    end
    run_md(3'd1, 32'd5, 32'hFFFFFFFD, ML, "multu");
    checks++;
    if (hi !== 32'h4 || lo !== 32'hFFFFFFF1) begin
      errors++;
      $display("[TB] FAIL multu_const: got %h_%h expected 00000004_fffffff1", hi, lo);
    end
  endtask

`ifdef ALU_MDU_DIV_EN
  task automatic test_div();
    run_md(3'd2, 32'hFFFFFFF9, 32'd2, DL, "div_neg");
    run_md(3'd2, 32'h80000000, 32'hFFFFFFFF, DL, "div_ovf");
    run_md(3'd3, 32'd9, 32'd0, DL, "divu_zero");
    run_md(3'd3, 32'hFFFFFFF0, 32'd7, DL, "divu");
    run_md(3'd2, 32'd100, 32'hFFFFFFF9, DL, "div_mixed");
  endtask
`endif

  // Back-to-back launches: the second start lands on the first idle edge.
  task automatic test_back_to_back();
    run_md(3'd1, 32'h12345678, 32'h9ABCDEF0, ML, "b2b_first");
    run_md(3'd0, 32'h80000000, 32'h80000000, ML, "b2b_second");
    run_md(3'd0, $urandom, $urandom, ML, "b2b_random");
  endtask

  // Ops that must leave HI/LO alone and never raise busy.
  task automatic test_ignored_ops();
    logic [2:0] ops[$] = '{3'd6, 3'd7};
    logic [31:0] old_hi, old_lo;
`ifndef ALU_MDU_DIV_EN
    ops.push_back(3'd2);
    ops.push_back(3'd3);
`endif
    test_mt(3'd4, 32'hCAFE0001);
    test_mt(3'd5, 32'hBEEF0002);
    foreach (ops[i]) begin
      old_hi = hi; old_lo = lo;
      md_start = 1'b1; md_op = ops[i]; A = 32'd9; B = 32'd0;
      @(negedge clk);
      md_start = 1'b0;
      checks++;
      if (busy !== 1'b0 || hi !== old_hi || lo !== old_lo) begin
        errors++;
        $display("[TB] FAIL ignored_op%0d: got busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", ops[i], busy, hi, lo, old_hi, old_lo);
      end
    end
  endtask

  // MTHI issued while a MULT is running must be dropped.
  task automatic test_ignored_start();
    logic [63:0] exp;
    int          cycles;
    sb.push_back(model_mul(3'd0, 32'd5, 32'hFFFFFFFD));
    md_start = 1'b1; md_op = 3'd0; A = 32'd5; B = 32'hFFFFFFFD;
    @(negedge clk);
    md_start = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      if (cycles == 2) begin
        md_start = 1'b1; md_op = 3'd4; A = 32'h1234;
      end else begin
        md_start = 1'b0;
      end
      @(negedge clk);
    end
    md_start = 1'b0;
    checks++;
    if (cycles != ML) begin
      errors++;
      $display("[TB] FAIL ignored_start_busy: got %0d expected %0d", cycles, ML);
    end
    exp = sb.pop_front();
    checks++;
    if ({hi, lo} !== exp) begin
      errors++;
      $display("[TB] FAIL ignored_start_result: got %h_%h expected %h_%h", hi, lo, exp[63:32], exp[31:0]);
    end
  endtask

  // Reset asserted in the third busy cycle aborts and clears everything.
  task automatic test_reset_mid_run();
    int cycles;
    test_mt(3'd4, 32'hAAAA);
    test_mt(3'd5, 32'h5555);
`ifdef ALU_MDU_DIV_EN
    md_op = 3'd2;
`else
    md_op = 3'd0;
`endif
    md_start = 1'b1; A = 32'd100; B = 32'd3;
    @(negedge clk);
    md_start = 1'b0;
    cycles = 1;
    while (busy && cycles < 3) begin
      cycles++;
      @(negedge clk);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    @(negedge clk); reset = 1'b1;
    repeat (DL + 3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("[TB] FAIL reset_no_late_write: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mt(3'd4, 32'h11112222);
    test_mt(3'd5, 32'h33334444);
    test_mult();
`ifdef ALU_MDU_DIV_EN
    test_div();
`endif
    test_back_to_back();
    test_ignored_ops();
    test_ignored_start();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
